// File: rtl/checker_stream_sched.sv
// rtl/checker_stream_sched.sv - round-robin scheduler sharing one trace-format checker between N_SRC sources
// Optional stall timeout in LOAD/DRAIN is enabled by defining CHK_SCHED_TIMEOUT_EN.
module checker_stream_sched #(
  parameter int         N_SRC     = 2,
  parameter int         MAX_LEN   = 64,
  parameter logic [7:0] IDLE_CHAR = 8'h00,
  parameter int         TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [8*N_SRC-1:0]         src_char,
  input  logic [N_SRC-1:0]           src_valid,
  output logic [N_SRC-1:0]           src_ready,
  output logic [7:0]                 chk_char,
  input  logic [1:0]                 chk_format,
  output logic                       res_valid,
  output logic [$clog2(N_SRC)-1:0]   res_src,
  output logic [1:0]                 res_format,
  output logic [1:0]                 res_err,
  output logic                       busy
);

  localparam int         GW       = $clog2(N_SRC);
  localparam int         AW       = $clog2(MAX_LEN);
  localparam int         CW       = $clog2(MAX_LEN + 1);
  localparam logic [7:0] END_CHAR = 8'h23;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_REPLAY, S_WAIT, S_RESULT
  } state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   last, g, grant_idx, cand;
  logic            grant_found;
  logic [7:0]      buf_mem [MAX_LEN];
  logic [CW-1:0]   cnt, len, rcnt;
  logic [7:0]      cur_char;
  logic            accepting, xfer, is_end, timed_out;

  assign accepting = (state == S_LOAD) || (state == S_DRAIN);
  assign cur_char  = src_char[{g, 3'b000} +: 8];
  assign xfer      = accepting && src_valid[g];
  assign is_end    = (cur_char == END_CHAR);
  assign res_valid = (state == S_RESULT);
  assign busy      = (state != S_IDLE);

  // First valid source strictly after the last grant, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = GW'((int'(last) + k) % N_SRC);
      if (!grant_found && src_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

`ifdef CHK_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (accepting && !xfer) begin
      stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

  assign timed_out = accepting && !xfer && (stall_cnt == TW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0 & (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    src_ready = '0;
    case (state)
      S_IDLE: begin
        if (grant_found) state_nx = S_LOAD;
      end
      S_LOAD: begin
        src_ready[g] = 1'b1;
        if (timed_out) begin
          state_nx = S_RESULT;
        end else if (xfer) begin
          if (is_end)                        state_nx = S_REPLAY;
          else if (cnt == CW'(MAX_LEN - 1))  state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        src_ready[g] = 1'b1;
        if (timed_out || (xfer && is_end)) state_nx = S_RESULT;
      end
      S_REPLAY: begin
        if (rcnt == len) state_nx = S_WAIT;
      end
      S_WAIT:   state_nx = S_RESULT;
      S_RESULT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if ((state == S_LOAD) && xfer) buf_mem[cnt[AW-1:0]] <= cur_char;
  end

  // Replay leaves REPLAY one cycle after '#' was put on chk_char so the
  // checker consumes it before WAIT samples its verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last       <= GW'(N_SRC - 1);
      g          <= '0;
      cnt        <= '0;
      len        <= '0;
      rcnt       <= '0;
      chk_char   <= IDLE_CHAR;
      res_src    <= '0;
      res_format <= '0;
      res_err    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            g    <= grant_idx;
            last <= grant_idx;
            cnt  <= '0;
          end
        end
        S_LOAD: begin
          if (timed_out) begin
            res_src    <= g;
            res_format <= 2'b00;
            res_err    <= 2'b10;
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
            if (is_end) begin
              len  <= cnt + 1'b1;
              rcnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (timed_out || (xfer && is_end)) begin
            res_src    <= g;
            res_format <= 2'b00;
            res_err    <= timed_out ? 2'b10 : 2'b01;
          end
        end
        S_REPLAY: begin
          if (rcnt != len) begin
            chk_char <= buf_mem[rcnt[AW-1:0]];
            rcnt     <= rcnt + 1'b1;
          end else begin
            chk_char <= IDLE_CHAR;
          end
        end
        S_WAIT: begin
          res_src    <= g;
          res_format <= chk_format;
          res_err    <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_checker_stream_sched.sv
// tb/tb_checker_stream_sched.sv - directed, table-driven bench for checker_stream_sched
// Covers the CHK_SCHED_TIMEOUT_EN stall-timeout case when that macro is defined.
module tb_checker_stream_sched;
  localparam int N  = 2;
  localparam int ML = 64;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [8*N-1:0] src_char;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_ready;
  logic [7:0]     chk_char;
  logic [1:0]     chk_format = 2'd3;
  logic           res_valid;
  logic [0:0]     res_src;
  logic [1:0]     res_format;
  logic [1:0]     res_err;
  logic           busy;

  logic [7:0] sc [N];
  logic       sv [N];
  assign src_char  = {sc[1], sc[0]};
  assign src_valid = {sv[1], sv[0]};

  checker_stream_sched #(.N_SRC(N), .MAX_LEN(ML), .IDLE_CHAR(8'h00), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .src_char(src_char), .src_valid(src_valid),
    .src_ready(src_ready), .chk_char(chk_char), .chk_format(chk_format),
    .res_valid(res_valid), .res_src(res_src), .res_format(res_format),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_str(string name, string act, string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Checker model: reports cur_fmt only in the cycle after it consumed '#'.
  logic [1:0] cur_fmt = 2'd0;
  bit         last_hash = 1'b0;
  always @(negedge clk) last_hash = (chk_char == 8'h23);
  always @(posedge clk) begin
    #1;
    chk_format = last_hash ? cur_fmt : 2'd3;
  end

  typedef struct {
    int    src;
    int    fmt;
    int    err;
    string msg;
    int    gaps;
    int    cyc;
  } res_t;

  res_t       rq[$];
  string      cap = "";
  bit         started = 1'b0, done = 1'b0;
  int         gaps = 0;
  int         ready_viol = 0;
  logic [1:0] exp_mask = 2'b11;

  always @(negedge clk) begin
    if (!reset) begin
      cap = ""; started = 1'b0; done = 1'b0; gaps = 0;
    end else begin
      if (chk_char != 8'h00) begin
        started = 1'b1;
        cap = {cap, " "};
        cap.putc(cap.len() - 1, chk_char);
        if (chk_char == 8'h23) done = 1'b1;
      end else if (started && !done) begin
        gaps++;
      end
      if (($countones(src_ready) > 1) || ((src_ready & ~exp_mask) != 2'b00)) ready_viol++;
      if (res_valid) begin
        rq.push_back('{int'(res_src), int'(res_format), int'(res_err), cap, gaps, cyc});
        cap = ""; started = 1'b0; done = 1'b0; gaps = 0;
      end
    end
  end

  task automatic send(int s, string m, int stall, output int c0);
    int w;
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < m.len(); i++) begin
      sc[s] = m[i];
      sv[s] = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!src_ready[s] && w < 3000);
      if (!src_ready[s]) begin
        check("ready_wait", int'(src_ready[s]), 1);
        sv[s] = 1'b0;
        return;
      end
      @(posedge clk); #1;
      sv[s] = 1'b0;
      if (stall > 0 && i < m.len() - 1) begin
        repeat (stall) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_result(output res_t r);
    int w = 0;
    while (rq.size() == 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (rq.size() == 0) begin
      check("result_wait", rq.size(), 1);
      r = '{-1, -1, -1, "", -1, -1};
    end else begin
      r = rq.pop_front();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    sv[0] = 1'b0; sv[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rq.delete();
  endtask

  typedef struct {
    int    src;
    string msg;
    int    stall;
    int    fmt;
    int    err;
  } vec_t;

  vec_t  vt[6];
  string alt0[3] = '{"^a0#", "^a1x#", "^a2yy#"};
  string alt1[3] = '{"^b0#", "^b1x#", "^b2yy#"};
  int    c_a, c_b;
  res_t  r;

  initial begin
    string s64, s70;
    sv[0] = 1'b0; sv[1] = 1'b0; sc[0] = 8'h00; sc[1] = 8'h00;

    s64 = "^";
    repeat (62) s64 = {s64, "a"};
    s64 = {s64, "#"};
    s70 = "^";
    repeat (68) s70 = {s70, "b"};
    s70 = {s70, "#"};

    vt[0] = '{0, "^242@00003 0f4: $31 <=12345678#", 0, 1, 0};
    vt[1] = '{1, "^338@00003130: *00000088 <= ffffb528#", 5, 2, 0};
    vt[2] = '{0, "junk^1#", 0, 0, 0};
    vt[3] = '{1, "#", 0, 1, 0};
    vt[4] = '{0, s64, 0, 2, 0};
    vt[5] = '{1, s70, 0, 0, 1};

    // Reset is asynchronous: outputs must clear before any clock edge.
    #2 reset = 1'b0;
    #1;
    check("rst_src_ready", int'(src_ready), 0);
    check("rst_chk_char", int'(chk_char), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_src", int'(res_src), 0);
    check("rst_res_format", int'(res_format), 0);
    check("rst_res_err", int'(res_err), 0);
    check("rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vt[i]) begin
      exp_mask = 2'b01 << vt[i].src;
      cur_fmt  = 2'(vt[i].fmt);
      send(vt[i].src, vt[i].msg, vt[i].stall, c_a);
      wait_result(r);
      check($sformatf("v%0d_src", i), r.src, vt[i].src);
      check($sformatf("v%0d_fmt", i), r.fmt, vt[i].fmt);
      check($sformatf("v%0d_err", i), r.err, vt[i].err);
      check_str($sformatf("v%0d_replay", i), r.msg, (vt[i].err != 0) ? "" : vt[i].msg);
      check($sformatf("v%0d_gaps", i), r.gaps, 0);
      if (vt[i].stall == 0)
        check($sformatf("v%0d_latency", i), r.cyc - c_a,
              (vt[i].err != 0) ? vt[i].msg.len() + 1 : 2 * vt[i].msg.len() + 3);
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), int'(res_valid), 0);
      check($sformatf("v%0d_idle", i), int'(busy), 0);
    end
    check("ready_only_granted", ready_viol, 0);

    // Both sources contend from reset: grants must alternate 0,1,0,1,0,1.
    do_reset();
    exp_mask = 2'b11;
    cur_fmt  = 2'd2;
    fork
      begin for (int k = 0; k < 3; k++) send(0, alt0[k], 0, c_a); end
      begin for (int k = 0; k < 3; k++) send(1, alt1[k], 0, c_b); end
    join
    for (int k = 0; k < 6; k++) begin
      wait_result(r);
      check($sformatf("alt%0d_src", k), r.src, k % 2);
      check_str($sformatf("alt%0d_replay", k), r.msg, (k % 2 == 0) ? alt0[k / 2] : alt1[k / 2]);
      check($sformatf("alt%0d_fmt", k), r.fmt, 2);
    end
    check("alt_ready_exclusive", ready_viol, 0);

    // Reset in the middle of a replay discards the message.
    do_reset();
    exp_mask = 2'b11;
    cur_fmt  = 2'd1;
    send(1, "^abcdefgh#", 0, c_b);
    c_a = 0;
    do begin
      @(negedge clk);
      c_a++;
    end while (chk_char == 8'h00 && c_a < 100);
    check("mid_replay_reached", int'(chk_char != 8'h00), 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_chk_char", int'(chk_char), 0);
    check("mid_rst_res_valid", int'(res_valid), 0);
    check("mid_rst_src_ready", int'(src_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_rst_no_result", rq.size(), 0);
    fork
      send(0, "^x#", 0, c_a);
      send(1, "^y#", 0, c_b);
    join
    wait_result(r);
    check("post_rst_first_src", r.src, 0);
    check_str("post_rst_first_msg", r.msg, "^x#");
    wait_result(r);
    check("post_rst_second_src", r.src, 1);

`ifdef CHK_SCHED_TIMEOUT_EN
    do_reset();
    cur_fmt = 2'd1;
    fork
      send(0, "^24", 0, c_a);
      send(1, "^9#", 0, c_b);
    join
    wait_result(r);
    check("to_src", r.src, 0);
    check("to_err", r.err, 2);
    check("to_fmt", r.fmt, 0);
    check("to_latency", r.cyc - c_a, 20);
    check_str("to_replay", r.msg, "");
    wait_result(r);
    check("to_next_src", r.src, 1);
    check("to_next_err", r.err, 0);
    check("to_next_fmt", r.fmt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
